// File: rtl/btn_evt_pkg.sv
// Shared types and 27 MHz default timing constants for the button event block.
package btn_evt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      LONG  = 2'd2
   } btn_state_e;

   // 1 s long-press and 250 ms auto-repeat at 27 MHz
   localparam int unsigned LONG_CYC_DEF   = 27_000_000;
   localparam int unsigned REPEAT_CYC_DEF = 6_750_000;
   localparam int unsigned CNT_W_DEF      = 25;

endpackage

// File: rtl/btn_evt_ch.sv
// One button channel: press/release edge detect, long-press FSM and hold counter.
// Auto-repeat counter is present only when BTN_EVT_REPEAT_EN is defined.
module btn_evt_ch
   import btn_evt_pkg::*;
#(
   parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
   parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic p_i,
   output logic hold_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic repeat_o,
   output logic press_d_o
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

   if (LONG_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_cfg
      $error("btn_evt_ch: LONG_CYC and REPEAT_CYC must be >= 2");
   end

   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hold_q, press_q, press_d, release_q, release_d, long_q, long_d;

`ifdef BTN_EVT_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
   logic [CNT_W-1:0] rep_q, rep_d;
   logic             repeat_q, repeat_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      long_d    = 1'b0;
      press_d   = p_i & ~hold_q;
      release_d = ~p_i & hold_q;
`ifdef BTN_EVT_REPEAT_EN
      rep_d     = rep_q;
      repeat_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (p_i) begin
               state_d = PRESS;
               cnt_d   = '0;
            end
         end
         PRESS: begin
            // release takes priority over a threshold hit in the same cycle
            if (!p_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG;
               long_d  = 1'b1;
`ifdef BTN_EVT_REPEAT_EN
               rep_d   = '0;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LONG: begin
            if (!p_i) begin
               state_d = IDLE;
               cnt_d   = '0;
`ifdef BTN_EVT_REPEAT_EN
               rep_d   = '0;
            end else if (rep_q == REP_LAST) begin
               rep_d    = '0;
               repeat_d = 1'b1;
            end else begin
               rep_d = rep_q + 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hold_q    <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
         rep_q     <= '0;
         repeat_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_q    <= p_i;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
`ifdef BTN_EVT_REPEAT_EN
         rep_q     <= rep_d;
         repeat_q  <= repeat_d;
`endif
      end
   end

   assign hold_o    = hold_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;
   assign press_d_o = press_d;
`ifdef BTN_EVT_REPEAT_EN
   assign repeat_o  = repeat_q;
`else
   assign repeat_o  = 1'b0;
`endif

endmodule

// File: rtl/btn_event.sv
// N independent button-event channels plus a registered any_press summary.
// Define BTN_EVT_REPEAT_EN to enable auto-repeat pulses after a long press.
module btn_event
   import btn_evt_pkg::*;
#(
   parameter int unsigned BTN_WIDTH  = 8,
   parameter bit          ACTIVE_LOW = 1'b1,
   parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
   parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BTN_WIDTH-1:0] btn_in,
   output logic [BTN_WIDTH-1:0] btn_hold,
   output logic [BTN_WIDTH-1:0] press_pulse,
   output logic [BTN_WIDTH-1:0] release_pulse,
   output logic [BTN_WIDTH-1:0] long_pulse,
   output logic [BTN_WIDTH-1:0] repeat_pulse,
   output logic                 any_press
);

   logic [BTN_WIDTH-1:0] press_d;
   logic                 any_press_q;

   for (genvar gi = 0; gi < BTN_WIDTH; gi++) begin : g_ch
      btn_evt_ch #(
         .LONG_CYC   (LONG_CYC),
         .REPEAT_CYC (REPEAT_CYC),
         .CNT_W      (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .p_i       (btn_in[gi] ^ ACTIVE_LOW),
         .hold_o    (btn_hold[gi]),
         .press_o   (press_pulse[gi]),
         .release_o (release_pulse[gi]),
         .long_o    (long_pulse[gi]),
         .repeat_o  (repeat_pulse[gi]),
         .press_d_o (press_d[gi])
      );
   end

   // built from next-state press bits so it lines up with press_pulse
   always_ff @(posedge clk) begin
      if (rst) any_press_q <= 1'b0;
      else     any_press_q <= |press_d;
   end

   assign any_press = any_press_q;

endmodule

// File: tb/tb_btn_event.sv
// Scoreboard bench for btn_event: stimulus queues expected events, monitor checks them.
module tb_btn_event;

   localparam int W = 4;

   typedef struct {
      int           cyc;
      logic [W-1:0] pr;
      logic [W-1:0] rl;
      logic [W-1:0] lg;
      logic [W-1:0] rp;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] btn_in;
   logic [W-1:0] btn_hold, press_pulse, release_pulse, long_pulse, repeat_pulse;
   logic         any_press;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   ev_t  exp_q[$];
   logic [W-1:0] exp_hold = '0;

   btn_event #(
      .BTN_WIDTH  (W),
      .ACTIVE_LOW (1'b1),
      .LONG_CYC   (10),
      .REPEAT_CYC (4),
      .CNT_W      (5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .btn_hold      (btn_hold),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse),
      .any_press     (any_press)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      exp_hold <= rst ? '0 : ~btn_in;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s at cyc %0d: got %h, required %h", nm, cyc, act, req);
      end
   endtask

   // kind: 0 press, 1 release, 2 long, 3 repeat; merges events of the same cycle
   task automatic add_ev(input int c, input int kind, input logic [W-1:0] m);
      ev_t e;
      e.cyc = c; e.pr = '0; e.rl = '0; e.lg = '0; e.rp = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].cyc == c) begin
            e = exp_q[i];
            case (kind)
               0: e.pr |= m;
               1: e.rl |= m;
               2: e.lg |= m;
               default: e.rp |= m;
            endcase
            exp_q[i] = e;
            return;
         end
         if (exp_q[i].cyc > c) begin
            case (kind)
               0: e.pr = m;
               1: e.rl = m;
               2: e.lg = m;
               default: e.rp = m;
            endcase
            exp_q.insert(i, e);
            return;
         end
      end
      case (kind)
         0: e.pr = m;
         1: e.rl = m;
         2: e.lg = m;
         default: e.rp = m;
      endcase
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {8'h0, btn_hold, press_pulse, release_pulse, long_pulse, repeat_pulse, 3'b0, any_press};
   endfunction

   // monitor: every cycle checks hold level, and pops/compares on any pulse activity
   always @(negedge clk) begin
      ev_t e;
      logic active;
      check("btn_hold", {28'h0, btn_hold}, {28'h0, exp_hold});
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         check($sformatf("missed_event_cyc%0d", e.cyc), 32'd0, 32'd1);
      end
      active = |{press_pulse, release_pulse, long_pulse, repeat_pulse, any_press};
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         $display("cyc=%0d press=%b release=%b long=%b repeat=%b any=%b",
                  cyc, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press);
         check("press_pulse",   {28'h0, press_pulse},   {28'h0, e.pr});
         check("release_pulse", {28'h0, release_pulse}, {28'h0, e.rl});
         check("long_pulse",    {28'h0, long_pulse},    {28'h0, e.lg});
         check("repeat_pulse",  {28'h0, repeat_pulse},  {28'h0, e.rp});
         check("any_press",     {31'h0, any_press},     {31'h0, |e.pr});
      end else if (active) begin
         $display("cyc=%0d press=%b release=%b long=%b repeat=%b any=%b (unexpected)",
                  cyc, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press);
         check("unexpected_event", {31'h0, active}, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      rst    = 1'b1;
      btn_in = 4'hF;
      // 1. reset with all released
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("reset_outs", all_outs(), 32'd0);
      end
      rst = 1'b0;
      tick(3);
      check("post_reset_outs", all_outs(), 32'd0);

      // 2. short press on ch0
      btn_in[0] = 1'b0;
      add_ev(cyc + 1, 0, 4'b0001);
      tick(5);
      btn_in[0] = 1'b1;
      add_ev(cyc + 1, 1, 4'b0001);
      tick(4);

      // 3. long hold on ch1
      btn_in[1] = 1'b0;
      e = cyc + 1;
      add_ev(e, 0, 4'b0010);
      add_ev(e + 10, 2, 4'b0010);
`ifdef BTN_EVT_REPEAT_EN
      add_ev(e + 14, 3, 4'b0010);
      add_ev(e + 18, 3, 4'b0010);
`endif
      tick(20);
      btn_in[1] = 1'b1;
      add_ev(cyc + 1, 1, 4'b0010);
      tick(4);

      // 4. release in the threshold cycle, then a fresh full-length press
      btn_in[0] = 1'b0;
      add_ev(cyc + 1, 0, 4'b0001);
      tick(10);
      btn_in[0] = 1'b1;
      add_ev(cyc + 1, 1, 4'b0001);
      tick(2);
      btn_in[0] = 1'b0;
      e = cyc + 1;
      add_ev(e, 0, 4'b0001);
      add_ev(e + 10, 2, 4'b0001);
      tick(12);
      btn_in[0] = 1'b1;
      add_ev(cyc + 1, 1, 4'b0001);
      tick(3);

      // 5. two channels pressed together
      btn_in[3:2] = 2'b00;
      add_ev(cyc + 1, 0, 4'b1100);
      tick(3);
      btn_in[3:2] = 2'b11;
      add_ev(cyc + 1, 1, 4'b1100);
      tick(3);

      // 6. reset while ch1 is in LONG; key stays held through reset
      btn_in[1] = 1'b0;
      e = cyc + 1;
      add_ev(e, 0, 4'b0010);
      add_ev(e + 10, 2, 4'b0010);
      tick(12);
      rst = 1'b1;
      tick(1);
      check("mid_reset_outs", all_outs(), 32'd0);
      tick(1);
      rst = 1'b0;
      e = cyc + 1;
      add_ev(e, 0, 4'b0010);
      add_ev(e + 10, 2, 4'b0010);
      tick(12);
      btn_in[1] = 1'b1;
      add_ev(cyc + 1, 1, 4'b0010);
      tick(4);

      check("events_left", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
